bin_to_bcd_param: RTL
=====================

BIN_TO_BCD_PARAM -- requirements
Module: bin_to_bcd_param

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, binary input width in bits (legal 4..32).
REQ-002 SHALL provide parameter DIGITS, default 5, number of BCD output digits (legal 1..10).
REQ-003 SHALL provide port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  synchronous active-high reset, sampled on clk rising edge.
REQ-005 SHALL provide port numero_input  input  WIDTH  unsigned binary value, sampled only when a start is accepted.
REQ-006 SHALL provide port start  input  1  conversion request, level-sampled each cycle.
REQ-007 SHALL provide port busy  output  1  high while a conversion is in progress (SHIFT and DONE states).
REQ-008 SHALL provide port ready  output  1  one-cycle pulse marking valid new result.
REQ-009 SHALL provide port digits_output  output  4*DIGITS  BCD result, digit 0 (units) in bits [3:0], digit k in bits [4k+3:4k].
REQ-010 SHALL provide port ovf  output  1  result-exceeds-range flag (see Configuration).

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-012 In IDLE with start=1, SHALL capture numero_input into a shift register, clear BCD scratch, load bit counter with WIDTH, go to SHIFT.
REQ-013 In IDLE with start=0, SHALL remain in IDLE with all outputs holding.
REQ-014 In SHIFT, each cycle SHALL add 3 to every scratch digit >= 5, then shift scratch:binary left by one (double-dabble), decrement counter.
REQ-015 SHALL leave SHIFT after exactly WIDTH shift cycles and enter DONE.
REQ-016 In DONE, SHALL register scratch into digits_output, assert ready for exactly one cycle, return to IDLE next cycle.
REQ-017 Latency: start sampled high at edge N SHALL produce ready=1 in the cycle after edge N+WIDTH+1; throughput one conversion per WIDTH+2 cycles.
REQ-018 start asserted while busy=1 (SHIFT or DONE) SHALL be ignored, not queued; numero_input changes during busy SHALL not affect the result.
REQ-019 start held continuously high SHALL launch a new conversion on the first IDLE cycle after each DONE.
REQ-020 digits_output and ovf SHALL hold the last completed result until the next DONE.
REQ-021 When input exceeds 10^DIGITS-1, digits_output SHALL equal value modulo 10^DIGITS (upper digits discarded).
REQ-022 Every output digit SHALL be in range 0..9 for all inputs.

Reset
REQ-023 rst=1 SHALL force IDLE, busy=0, ready=0, digits_output=0, ovf=0, counter=0, scratch=0 on the next edge.
REQ-024 rst asserted mid-conversion SHALL abort it with no ready pulse; rst SHALL take priority over start in the same cycle.

Configuration
REQ-025 Macro BCD_OVF_DETECT_EN defined: ovf SHALL be registered in DONE as 1 when captured input > 10^DIGITS-1, else 0, valid with ready.
REQ-026 Macro BCD_OVF_DETECT_EN undefined: no comparison logic SHALL be synthesised and ovf SHALL be tied constant 0.

Verification
REQ-027 WIDTH=16, DIGITS=4, start with 1234 -> ready after 17 edges, digits 1,2,3,4, ovf=0.
REQ-028 Same config: 5678 then 910 back-to-back (start held high) -> 5,6,7,8 then 0,9,1,0, ready pulses 18 cycles apart.
REQ-029 WIDTH=16, DIGITS=5: input 0 -> 0,0,0,0,0; input 65535 -> 6,5,5,3,5, ovf=0.
REQ-030 WIDTH=16, DIGITS=4, BCD_OVF_DETECT_EN defined: 12345 -> digits 2,3,4,5, ovf=1; macro undefined -> same digits, ovf=0.
REQ-031 Start 1234, toggle start and change numero_input to 9999 at cycle 5 -> result still 1,2,3,4, single ready pulse.
REQ-032 Start 5678, assert rst at cycle 8 -> no ready, busy=0, digits_output=0 next cycle; next start 42 -> 0,0,4,2.

Source files
------------

// File: rtl/bin_to_bcd_param.sv
// Sequential binary-to-BCD converter using double-dabble, one bit per cycle.
// Optional build macro: BCD_OVF_DETECT_EN adds an overflow flag that reports
// when the captured input does not fit in DIGITS decimal digits.
module bin_to_bcd_param #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      numero_input,
  input  logic                  start,
  output logic                  busy,
  output logic                  ready,
  output logic [4*DIGITS-1:0]   digits_output,
  output logic                  ovf
);

  localparam int unsigned LP_BCD_W = 4 * DIGITS;
  localparam int unsigned LP_CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WIDTH-1:0]      r_bin;
  logic [WIDTH-1:0]      w_bin_nxt;
  logic [LP_BCD_W-1:0]   r_bcd;
  logic [LP_BCD_W-1:0]   w_bcd_nxt;
  logic [LP_BCD_W-1:0]   w_bcd_adj;
  logic [LP_CNT_W-1:0]   r_cnt;
  logic [LP_CNT_W-1:0]   w_cnt_nxt;
  logic                  r_busy;
  logic                  w_busy_nxt;
  logic                  r_ready;
  logic                  w_ready_nxt;
  logic [LP_BCD_W-1:0]   r_digits;
  logic [LP_BCD_W-1:0]   w_digits_nxt;

  // Add-3 correction on every scratch digit that would overflow when doubled
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // Next-state and datapath updates; carry out of the top digit is dropped,
  // which yields the value modulo 10^DIGITS
  always_comb begin
    w_state_nxt  = r_state;
    w_bin_nxt    = r_bin;
    w_bcd_nxt    = r_bcd;
    w_cnt_nxt    = r_cnt;
    w_ready_nxt  = 1'b0;
    w_digits_nxt = r_digits;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SHIFT;
          w_bin_nxt   = numero_input;
          w_bcd_nxt   = '0;
          w_cnt_nxt   = LP_CNT_W'(WIDTH);
        end
      end
      ST_SHIFT: begin
        w_bcd_nxt = {w_bcd_adj[LP_BCD_W-2:0], r_bin[WIDTH-1]};
        w_bin_nxt = {r_bin[WIDTH-2:0], 1'b0};
        w_cnt_nxt = r_cnt - LP_CNT_W'(1);
        if (r_cnt == LP_CNT_W'(1)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_digits_nxt = r_bcd;
        w_ready_nxt  = 1'b1;
        w_state_nxt  = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_bin    <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_ready  <= 1'b0;
      r_digits <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_bin    <= w_bin_nxt;
      r_bcd    <= w_bcd_nxt;
      r_cnt    <= w_cnt_nxt;
      r_busy   <= w_busy_nxt;
      r_ready  <= w_ready_nxt;
      r_digits <= w_digits_nxt;
    end
  end

  assign busy          = r_busy;
  assign ready         = r_ready;
  assign digits_output = r_digits;

`ifdef BCD_OVF_DETECT_EN
  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int unsigned k = 0; k < n; k++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  localparam logic [63:0] LP_MAX_VAL = pow10(DIGITS) - 64'd1;

  logic [WIDTH-1:0] r_cap;
  logic             r_ovf;

  // Keep an unshifted copy of the accepted input for the range check
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_cap <= numero_input;
    end
  end

  // Overflow flag updates together with the result in DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == ST_DONE) begin
      r_ovf <= (64'(r_cap) > LP_MAX_VAL);
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule
